// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller signal bundle.
//   master : ID-stage side; drives the ID instruction fields and hold,
//            receives the stage enables, bubble, forwarding selects,
//            stall counter and FSM state.
//   slave  : the hazard controller itself (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_raddr1;
    logic [3:0]  id_raddr2;
    logic        id_uses_r2;
    logic        id_wen;
    logic [3:0]  id_waddr;
    logic        hold;
    logic        pc_en;
    logic        ifid_en;
    logic        idexe_en;
    logic        idexe_bubble;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    modport master (
        output id_valid, id_raddr1, id_raddr2, id_uses_r2, id_wen, id_waddr, hold,
        input  pc_en, ifid_en, idexe_en, idexe_bubble, fwd_sel1, fwd_sel2,
               stall_cnt, state
    );

    modport slave (
        input  id_valid, id_raddr1, id_raddr2, id_uses_r2, id_wen, id_waddr, hold,
        output pc_en, ifid_en, idexe_en, idexe_bubble, fwd_sel1, fwd_sel2,
               stall_cnt, state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline data-hazard controller.
// Tracks the destination register of the writing instructions in EXE and S4
// and either stalls the ID instruction (bubble into ID/EXE, PC and IF/ID held)
// or, when built with PIPE_HAZARD_FORWARDING_EN defined, selects a forwarding
// source instead of stalling.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : pipe_hazard_ctrl_if.slave -- ID instruction fields, hold request,
//          stage enables, idexe_bubble, fwd_sel1/2, stall_cnt, state
module pipe_hazard_ctrl (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STALL  = 2'b10,
        FREEZE = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        exe_v, s4_v;
    logic [3:0]  exe_wa, s4_wa;
    logic [15:0] stall_cnt_q;
    logic        m1_exe, m1_s4, m2_exe, m2_s4;
    logic        stall;
    logic [1:0]  fwd1, fwd2;
    logic        pc_en_c, ifid_en_c, idexe_en_c, bubble_c;

    // Register 0 is deliberately not excluded: every address can hazard.
    always_comb begin
        m1_exe = bus.id_valid && exe_v && (bus.id_raddr1 == exe_wa);
        m1_s4  = bus.id_valid && s4_v  && (bus.id_raddr1 == s4_wa);
        m2_exe = bus.id_valid && bus.id_uses_r2 && exe_v && (bus.id_raddr2 == exe_wa);
        m2_s4  = bus.id_valid && bus.id_uses_r2 && s4_v  && (bus.id_raddr2 == s4_wa);
    end

`ifdef PIPE_HAZARD_FORWARDING_EN
    // EXE holds the younger result, so it wins over S4.
    always_comb begin
        fwd1  = m1_exe ? 2'b01 : (m1_s4 ? 2'b10 : 2'b00);
        fwd2  = m2_exe ? 2'b01 : (m2_s4 ? 2'b10 : 2'b00);
        stall = 1'b0;
    end
`else
    always_comb begin
        fwd1  = '0;
        fwd2  = '0;
        stall = m1_exe | m1_s4 | m2_exe | m2_s4;
    end
`endif

    always_comb begin
        state_d    = state_q;
        pc_en_c    = 1'b0;
        ifid_en_c  = 1'b0;
        idexe_en_c = 1'b0;
        bubble_c   = 1'b0;
        if (!rst) begin
            state_d = IDLE;
        end else if (bus.hold) begin
            state_d = FREEZE;
        end else begin
            pc_en_c    = ~stall;
            ifid_en_c  = ~stall;
            idexe_en_c = 1'b1;
            bubble_c   = stall;
            unique case (state_q)
                IDLE:    if (bus.id_valid) state_d = RUN;
                RUN:     if (stall)        state_d = STALL;
                STALL:   if (!stall)       state_d = RUN;
                FREEZE:                    state_d = RUN;
                default:                   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // A bubble enters EXE as a non-writer, so a stalled reader waits only
    // until the real writer has moved past S4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_v  <= 1'b0;
            exe_wa <= '0;
            s4_v   <= 1'b0;
            s4_wa  <= '0;
        end else if (idexe_en_c) begin
            s4_v   <= exe_v;
            s4_wa  <= exe_wa;
            exe_v  <= bus.id_valid & bus.id_wen & ~bubble_c;
            exe_wa <= bus.id_waddr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_q <= '0;
        else if (bubble_c && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.pc_en        = pc_en_c;
    assign bus.ifid_en      = ifid_en_c;
    assign bus.idexe_en     = idexe_en_c;
    assign bus.idexe_bubble = bubble_c;
    assign bus.fwd_sel1     = rst ? fwd1 : 2'b00;
    assign bus.fwd_sel2     = rst ? fwd2 : 2'b00;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Expected outputs come from
// hand-derived per-cycle tables; PIPE_HAZARD_FORWARDING_EN selects the
// forwarding-build expectations.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [3:0] r1;
        logic [3:0] r2;
        logic       u2;
        logic       wen;
        logic [3:0] wa;
        logic       hold;
        logic       rst_v;
    } stim_t;

    typedef struct {
        string       name;
        logic [9:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [3:0] EN_RUN = 4'b1110;  // {pc_en, ifid_en, idexe_en, bubble}
    localparam logic [3:0] EN_STL = 4'b0011;
    localparam logic [3:0] EN_OFF = 4'b0000;
    localparam logic [1:0] ST_I = 2'b00, ST_R = 2'b01, ST_S = 2'b10, ST_F = 2'b11;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t st(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                                 input logic u2, input logic wen, input logic [3:0] wa,
                                 input logic hold = 1'b0, input logic rst_v = 1'b1);
        return '{v: v, r1: r1, r2: r2, u2: u2, wen: wen, wa: wa, hold: hold, rst_v: rst_v};
    endfunction

    function automatic exp_t ex(input string n, input logic [3:0] en, input logic [1:0] f1,
                                input logic [1:0] f2, input logic [1:0] s, input logic [15:0] c);
        exp_t e;
        e.name = n;
        e.ctl  = {en, f1, f2, s};
        e.cnt  = c;
        return e;
    endfunction

    function automatic logic [9:0] obs_ctl();
        return {bus.pc_en, bus.ifid_en, bus.idexe_en, bus.idexe_bubble,
                bus.fwd_sel1, bus.fwd_sel2, bus.state};
    endfunction

    task automatic apply(input stim_t s);
        rst              = s.rst_v;
        bus.id_valid     = s.v;
        bus.id_raddr1    = s.r1;
        bus.id_raddr2    = s.r2;
        bus.id_uses_r2   = s.u2;
        bus.id_wen       = s.wen;
        bus.id_waddr     = s.wa;
        bus.hold         = s.hold;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(st(1, 3, 3, 1, 1, 3, 0, 0)); e.push_back(ex("rst_active",      EN_OFF, 0, 0, ST_I, 0));
        s.push_back(st(1, 3, 3, 1, 1, 3, 1, 0)); e.push_back(ex("rst_active_hold", EN_OFF, 0, 0, ST_I, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0));       e.push_back(ex("rst_released",    EN_RUN, 0, 0, ST_I, 0));
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // ADD r3 <- r1,r2 then ADD r5 <- r3,r1
    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 3)); e.push_back(ex("b2b_writer", EN_RUN, 0, 0, ST_I, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("b2b_fwd_exe", EN_RUN, 2'b01, 0, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("b2b_after",   EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("b2b_bubble1", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("b2b_bubble2", EN_STL, 0, 0, ST_S, 1));
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("b2b_issue",   EN_RUN, 0, 0, ST_S, 2));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("b2b_after",   EN_RUN, 0, 0, ST_R, 2));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // writer r3, independent instruction, reader r3
    task automatic test_s4_match();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 3)); e.push_back(ex("s4_writer", EN_RUN, 0, 0, ST_I, 0));
        s.push_back(st(1, 1, 2, 1, 1, 6)); e.push_back(ex("s4_indep",  EN_RUN, 0, 0, ST_R, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 3, 0, 1, 1, 7)); e.push_back(ex("s4_fwd",   EN_RUN, 2'b10, 0, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("s4_after", EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 3, 0, 1, 1, 7)); e.push_back(ex("s4_bubble", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(1, 3, 0, 1, 1, 7)); e.push_back(ex("s4_issue",  EN_RUN, 0, 0, ST_S, 1));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("s4_after",  EN_RUN, 0, 0, ST_R, 1));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // EXE and S4 both write r4, ID reads r4
    task automatic test_forward_priority();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 4)); e.push_back(ex("fp_writer1", EN_RUN, 0, 0, ST_I, 0));
        s.push_back(st(1, 1, 2, 1, 1, 4)); e.push_back(ex("fp_writer2", EN_RUN, 0, 0, ST_R, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 4, 2, 1, 1, 8)); e.push_back(ex("fp_exe_wins", EN_RUN, 2'b01, 0, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("fp_after",    EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 4, 2, 1, 1, 8)); e.push_back(ex("fp_bubble1", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(1, 4, 2, 1, 1, 8)); e.push_back(ex("fp_bubble2", EN_STL, 0, 0, ST_S, 1));
        s.push_back(st(1, 4, 2, 1, 1, 8)); e.push_back(ex("fp_issue",   EN_RUN, 0, 0, ST_S, 2));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("fp_after",   EN_RUN, 0, 0, ST_R, 2));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // r7 as unused operand 2 while in EXE, then used while in S4
    task automatic test_unused_r2();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 7)); e.push_back(ex("ur2_writer", EN_RUN, 0, 0, ST_I, 0));
        s.push_back(st(1, 1, 7, 0, 0, 9)); e.push_back(ex("ur2_unused", EN_RUN, 0, 0, ST_R, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 1, 7, 1, 0, 9)); e.push_back(ex("ur2_used_s4", EN_RUN, 0, 2'b10, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("ur2_after",   EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 1, 7, 1, 0, 9)); e.push_back(ex("ur2_used_s4", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ex("ur2_after",   EN_RUN, 0, 0, ST_S, 1));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // writer r0, reader r0 through operand 2
    task automatic test_reg_zero();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 0)); e.push_back(ex("r0_writer", EN_RUN, 0, 0, ST_I, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_fwd_exe", EN_RUN, 0, 2'b01, ST_R, 0));
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_fwd_s4",  EN_RUN, 0, 2'b10, ST_R, 0));
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_clear",   EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_bubble1", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_bubble2", EN_STL, 0, 0, ST_S, 1));
        s.push_back(st(1, 5, 0, 1, 0, 9)); e.push_back(ex("r0_issue",   EN_RUN, 0, 0, ST_S, 2));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // hold raised during a stall, then released
    task automatic test_hold();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 3)); e.push_back(ex("hold_writer", EN_RUN, 0, 0, ST_I, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_fwd",     EN_RUN, 2'b01, 0, ST_R, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5, 1)); e.push_back(ex("hold_on",      EN_OFF, 2'b10, 0, ST_R, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5, 1)); e.push_back(ex("hold_freeze",  EN_OFF, 2'b10, 0, ST_F, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_release", EN_RUN, 2'b10, 0, ST_F, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_clear",   EN_RUN, 0, 0, ST_R, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0));    e.push_back(ex("hold_after",   EN_RUN, 0, 0, ST_R, 0));
`else
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_bubble1", EN_STL, 0, 0, ST_R, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5, 1)); e.push_back(ex("hold_on",      EN_OFF, 0, 0, ST_S, 1));
        s.push_back(st(1, 3, 1, 1, 1, 5, 1)); e.push_back(ex("hold_freeze",  EN_OFF, 0, 0, ST_F, 1));
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_resume",  EN_STL, 0, 0, ST_F, 1));
        s.push_back(st(1, 3, 1, 1, 1, 5));    e.push_back(ex("hold_issue",   EN_RUN, 0, 0, ST_R, 2));
        s.push_back(st(0, 0, 0, 0, 0, 0));    e.push_back(ex("hold_after",   EN_RUN, 0, 0, ST_R, 2));
`endif
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    // reset pulsed mid-stall, then the same reader again
    task automatic test_reset_mid_stall();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        apply_reset();
        s.push_back(st(1, 1, 2, 1, 1, 3)); e.push_back(ex("rms_writer", EN_RUN, 0, 0, ST_I, 0));
`ifdef PIPE_HAZARD_FORWARDING_EN
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("rms_fwd", EN_RUN, 2'b01, 0, ST_R, 0));
`else
        s.push_back(st(1, 3, 1, 1, 1, 5)); e.push_back(ex("rms_bubble", EN_STL, 0, 0, ST_R, 0));
`endif
        s.push_back(st(1, 3, 1, 1, 1, 5, 0, 0)); e.push_back(ex("rms_in_reset",  EN_OFF, 0, 0, ST_I, 0));
        s.push_back(st(1, 3, 1, 1, 1, 5));       e.push_back(ex("rms_no_stall",  EN_RUN, 0, 0, ST_I, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0));       e.push_back(ex("rms_after",     EN_RUN, 0, 0, ST_R, 0));
        for (int unsigned i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); sb.push_back(e[i]);
            #3; g = sb.pop_front(); checks++;
            if (obs_ctl() !== g.ctl || bus.stall_cnt !== g.cnt) begin
                errors++;
                $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", g.name, obs_ctl(), bus.stall_cnt, g.ctl, g.cnt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_back_to_back();
        test_s4_match();
        test_forward_priority();
        test_unused_r2();
        test_reg_zero();
        test_hold();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (asserted at 0).
REQ-003 The block SHALL have port id_valid, input, 1 bit: instruction present in ID.
REQ-004 The block SHALL have ports id_raddr1 and id_raddr2, input, 4 bits each: ID source register addresses.
REQ-005 The block SHALL have port id_uses_r2, input, 1 bit: 1 when the ID instruction reads rdata2 (alusrc=0).
REQ-006 The block SHALL have ports id_wen (input, 1 bit) and id_waddr (input, 4 bits): ID instruction writes register id_waddr.
REQ-007 The block SHALL have port hold, input, 1 bit: external freeze request.
REQ-008 The block SHALL have ports pc_en, ifid_en and idexe_en, output, 1 bit each: stage register enables.
REQ-009 The block SHALL have port idexe_bubble, output, 1 bit: load a NOP into ID/EXE this edge.
REQ-010 The block SHALL have ports fwd_sel1 and fwd_sel2, output, 2 bits each: operand source select (00 regfile, 01 aluout, 10 aluout_S4).
REQ-011 The block SHALL have port stall_cnt, output, 16 bits: saturating count of hazard-stall cycles.
REQ-012 The block SHALL have port state, output, 2 bits: FSM state (00 IDLE, 01 RUN, 10 STALL, 11 FREEZE).

Function
REQ-013 The block SHALL keep shadow tags {exe_v, exe_wa} and {s4_v, s4_wa} mirroring the writing instruction in EXE and S4.
REQ-014 The block SHALL, on each edge with idexe_en=1, shift s4 <= exe and load exe <= {id_valid & id_wen & ~idexe_bubble, id_waddr}.
REQ-015 The block SHALL flag a match for operand n when id_valid=1, the operand is used (operand 1 always, operand 2 only if id_uses_r2=1), and its address equals exe_wa with exe_v=1 or s4_wa with s4_v=1.
REQ-016 The block SHALL treat all 16 register addresses, including 0, as hazard-capable.
REQ-017 The block SHALL, on a match without forwarding, drive pc_en=0, ifid_en=0, idexe_en=1 and idexe_bubble=1, combinationally in the same cycle.
REQ-018 The block SHALL resolve any stall in at most 2 cycles (1 cycle for an S4 match, 2 cycles for an EXE match).
REQ-019 The block SHALL, when hold=1, drive pc_en=ifid_en=idexe_en=0 and idexe_bubble=0 and freeze shadows and stall_cnt; hold overrides any hazard.
REQ-020 The block SHALL drive pc_en=ifid_en=idexe_en=1 and idexe_bubble=0 when there is no hold and no stall.
REQ-021 The FSM SHALL leave IDLE to RUN on the first id_valid=1 with hold=0.
REQ-022 The FSM SHALL move RUN to STALL on a stalling match and STALL to RUN when no match remains.
REQ-023 The FSM SHALL move any state to FREEZE when hold=1, and FREEZE to RUN when hold=0.
REQ-024 The block SHALL increment stall_cnt once per cycle with idexe_bubble=1, saturating at 16'hFFFF with no wrap.

Reset
REQ-025 The block SHALL, while rst=0, clear exe_v, s4_v, exe_wa, s4_wa, stall_cnt and fwd_sel regs to 0 and set state=IDLE.
REQ-026 The block SHALL drive pc_en=ifid_en=idexe_en=0 and idexe_bubble=0 while rst=0.
REQ-027 The block SHALL, on reset mid-stall, drop all pending tags, so the first post-reset instruction never stalls.

Configuration
REQ-028 The block SHALL, with macro PIPE_HAZARD_FORWARDING_EN defined, never stall on a match and instead set fwd_selN=01 for an EXE match, 10 for an S4-only match and 00 otherwise, with EXE taking priority.
REQ-029 The block SHALL, without PIPE_HAZARD_FORWARDING_EN, tie fwd_sel1=fwd_sel2=00 and stall per REQ-017.

Verification
REQ-030 The bench SHALL check: back-to-back ADD r3 <- ... then ADD r5 <- r3,r1 with no macro -> 2 bubble cycles, pc_en low 2 cycles, stall_cnt=2.
REQ-031 The bench SHALL check: writer to r3, one independent instruction, then reader of r3 with no macro -> exactly 1 bubble (S4 match).
REQ-032 The bench SHALL check: EXE writes r4 and S4 writes r4, ID reads r4 with the macro defined -> fwd_sel1=01, no stall.
REQ-033 The bench SHALL check: ID reads r7 only as operand 2 with id_uses_r2=0 while EXE writes r7 -> no stall and fwd_sel2=00.
REQ-034 The bench SHALL check: hold=1 asserted during a STALL cycle -> all enables 0, state=11, stall_cnt frozen; hold released -> stall resumes and completes.
REQ-035 The bench SHALL check: rst=0 pulsed mid-stall -> enables 0 immediately, state=00, stall_cnt=0; the next reader of the same register runs with 0 bubbles.
